hazard_control_unit: RTL and testbench

// - Stall/flush controller for the 5-stage pipeline; counterpart of the forwarding unit.
// - Handles hazards that forwarding cannot resolve:
//   - load-use RAW: one-bubble stall.
//   - taken-branch redirect: IF/ID and ID/EX flush.
//   - multi-cycle data-memory access: full freeze until mem_ready, with a timeout watchdog.
// - Drives the stall/flush inputs of every pipeline register and the PC.

---
 rtl/hazard_control_unit.sv | 123 ++++++++++++
 tb/tb_hazard_control_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller: load-use, branch flush, dmem wait freeze
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_stall_cycles / perf_flushes counters.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1),
    parameter int PERF_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             flush_id_ex,
    output logic             stall_ex_mem,
    output logic             bubble_mem_wb,
    output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes
`endif
);

    typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  wait_cnt_q;
    logic              tmo_q;
    logic              mem_wait;
    logic              load_use;
    logic              tmo_hit;

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign tmo_hit  = mem_wait && (wait_cnt_q == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // counts every frozen cycle including the first, so the Nth wait cycle sees N-1
            if (!mem_wait) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != TMO_MAX) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_wait)  state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // outputs are gated by rst_n so an asserted reset silences them immediately
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        flush_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        bubble_mem_wb = 1'b0;
        mem_timeout   = 1'b0;
        if (rst_n) begin
            if (mem_wait) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                stall_ex_mem  = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            mem_timeout = tmo_q || tmo_hit;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic branch_honoured;
    assign branch_honoured = ex_branch_taken && !mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_pc)        perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (branch_honoured) perf_flushes      <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } vin_t;

    typedef struct packed {
        vin_t       vi;
        logic [7:0] exp;
    } vec_t;

    // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, stall_ex_mem, bubble_mem_wb, mem_timeout}
    localparam logic [7:0] E_NONE   = 8'b0000_0000;
    localparam logic [7:0] E_LU     = 8'b1100_1000;
    localparam logic [7:0] E_BR     = 8'b0010_1000;
    localparam logic [7:0] E_FRZ    = 8'b1101_0110;
    localparam logic [7:0] E_FRZ_T  = 8'b1101_0111;
    localparam logic [7:0] E_TMO    = 8'b0000_0001;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic       stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
    logic       stall_ex_mem, bubble_mem_wb, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    vec_t       vecs[12];

    hazard_control_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex), .stall_ex_mem(stall_ex_mem),
        .bubble_mem_wb(bubble_mem_wb), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vin_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic mr, input logic [4:0] rd,
                                input logic br, input logic mreq, input logic mrdy);
        vin_t v;
        v = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, mr: mr, rd: rd, br: br, mreq: mreq, mrdy: mrdy};
        return v;
    endfunction

    task automatic drive(input vin_t v);
        id_rs1_addr     = v.rs1;
        id_rs2_addr     = v.rs2;
        id_uses_rs1     = v.u1;
        id_uses_rs2     = v.u2;
        ex_mem_read     = v.mr;
        ex_rd_addr      = v.rd;
        ex_branch_taken = v.br;
        mem_req         = v.mreq;
        mem_ready       = v.mrdy;
    endtask

    task automatic check_out();
        logic [7:0] got, e;
        string      nm;
        got = {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
               stall_ex_mem, bubble_mem_wb, mem_timeout};
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %b required %b", nm, got, e);
        end
    endtask

    // one cycle: drive after the rising edge, push the expectation, compare at the falling edge
    task automatic step(input vin_t v, input logic [7:0] e, input string nm);
        @(posedge clk);
        #2;
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        check_out();
    endtask

    task automatic check_int(input int got, input int e, input string nm);
        n_cmp++;
        if (got != e) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, e);
        end
    endtask

    vin_t idle, wt, rdy;

    initial begin
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        wt   = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        rdy  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        vecs[0]  = '{mk(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), E_LU};
        vecs[1]  = '{idle, E_NONE};
        vecs[2]  = '{mk(5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), E_NONE};
        vecs[3]  = '{mk(5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), E_NONE};
        vecs[4]  = '{mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), E_BR};
        vecs[5]  = '{mk(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), E_LU};
        vecs[6]  = '{mk(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0), E_NONE};
        vecs[7]  = '{rdy, E_NONE};
        vecs[8]  = '{mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0), E_FRZ};
        vecs[9]  = '{rdy, E_NONE};
        vecs[10] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), E_NONE};
        vecs[11] = '{mk(5'd4, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0), E_LU};

        // reset with an active load-use pattern on the inputs
        rst_n = 1'b0;
        drive(vecs[0].vi);
        #7;
        exp_q.push_back(E_NONE);
        name_q.push_back("reset");
        check_out();
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].vi, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // three-cycle freeze, then completion
        for (int i = 0; i < 3; i++) step(wt, E_FRZ, $sformatf("wait3_c%0d", i + 1));
        step(rdy, E_NONE, "wait3_done");
        step(idle, E_NONE, "wait3_idle");

        // watchdog: ten wait cycles with MEM_TIMEOUT=4
        for (int i = 0; i < 10; i++)
            step(wt, (i < 4) ? E_FRZ : E_FRZ_T, $sformatf("tmo_c%0d", i + 1));
        step(rdy, E_TMO, "tmo_sticky_ready");
        step(idle, E_TMO, "tmo_sticky_idle");
        step(wt, E_FRZ_T, "tmo_rewait");

        // asynchronous reset in the middle of a wait cycle
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(E_NONE);
        name_q.push_back("reset_mid_wait");
        check_out();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(idle, E_NONE, "after_reset_idle");

`ifdef HAZARD_PERF_CNT_EN
        check_int(int'(perf_stall_cycles), 0, "perf_stall_reset");
        step(vecs[0].vi, E_LU, "perf_lu1");
        step(vecs[11].vi, E_LU, "perf_lu2");
        for (int i = 0; i < 3; i++) step(wt, E_FRZ, $sformatf("perf_wait%0d", i + 1));
        step(rdy, E_NONE, "perf_ready");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), E_BR, "perf_branch");
        step(idle, E_NONE, "perf_idle");
        check_int(int'(perf_stall_cycles), 5, "perf_stall_cycles");
        check_int(int'(perf_flushes), 1, "perf_flushes");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
